// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter
//   Shares one single-port, 1-cycle-latency RAM between NUM_PORTS requesters
//   using the req/gnt/rvalid protocol. Arbitration is round-robin, with a
//   bounded lock that lets one port make up to MAX_LOCK back-to-back accesses.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   req_i / lock_i    per-port request / keep-priority-after-this-grant
//   we_i, addr_i,     per-port payload; port k occupies slice k of each bus
//   be_i, wdata_i
//   gnt_o             one-hot grant, combinational in the request cycle
//   rvalid_o          one-hot response valid, one cycle after gnt_o
//   rdata_o           shared read data, qualified by rvalid_o
//   ram_*_o           RAM macro request side
//   ram_rdata_i       RAM read data, valid one cycle after ram_en_o
module ram_rr_arbiter #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LOCK   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            lock_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            ram_en_o,
  output logic                            ram_we_o,
  output logic [ADDR_WIDTH-1:0]           ram_addr_o,
  output logic [DATA_WIDTH/8-1:0]         ram_be_o,
  output logic [DATA_WIDTH-1:0]           ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]           ram_rdata_i
);

  localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam logic [3:0]  LockCap = 4'(MAX_LOCK - 1);
  localparam logic [PtrW-1:0] LastPort = PtrW'(NUM_PORTS - 1);

  logic [PtrW-1:0]      r_ptr;
  logic [3:0]           r_lock_cnt;
  logic [NUM_PORTS-1:0] r_rvalid;

  logic                 w_found;
  logic [PtrW-1:0]      w_gnt_idx;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [PtrW-1:0]      w_ptr_d;
  logic [3:0]           w_lock_cnt_d;
  int unsigned          w_idx;

  // Cyclic search from r_ptr; the first requester found wins. Grants are
  // forced off while reset is asserted.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    w_gnt     = '0;
    if (rst_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        w_idx = int'(r_ptr) + i;
        if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
        if (!w_found && req_i[w_idx]) begin
          w_found   = 1'b1;
          w_gnt_idx = PtrW'(w_idx);
        end
      end
      if (w_found) w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  // With no grant w_gnt_idx stays 0, so the RAM sees port 0's payload.
  always_comb begin
    ram_en_o    = w_found;
    ram_we_o    = we_i[w_gnt_idx];
    ram_addr_o  = addr_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    ram_be_o    = be_i[w_gnt_idx*BeW +: BeW];
    ram_wdata_o = wdata_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    gnt_o       = w_gnt;
    rvalid_o    = r_rvalid;
    rdata_o     = ram_rdata_i;
  end

  // A locking port keeps the pointer until it has taken MAX_LOCK grants in a
  // row; any idle cycle clears the lock count.
  always_comb begin
    w_ptr_d      = r_ptr;
    w_lock_cnt_d = '0;
    if (w_found) begin
      if (lock_i[w_gnt_idx] && (r_lock_cnt < LockCap)) begin
        w_ptr_d      = w_gnt_idx;
        w_lock_cnt_d = r_lock_cnt + 4'd1;
      end else begin
        w_ptr_d      = (w_gnt_idx == LastPort) ? '0 : w_gnt_idx + PtrW'(1);
        w_lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_lock_cnt <= '0;
      r_rvalid   <= '0;
    end else begin
      r_ptr      <= w_ptr_d;
      r_lock_cnt <= w_lock_cnt_d;
      r_rvalid   <= w_gnt;
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter (NUM_PORTS=3, 32-bit address/data,
// MAX_LOCK=4) with a small byte-enabled RAM model behind it.
module tb_ram_rr_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req_i, lock_i, we_i;
  logic [NP*AW-1:0]  addr_i;
  logic [NP*DW/8-1:0] be_i;
  logic [NP*DW-1:0]  wdata_i;
  logic [NP-1:0]     gnt_o, rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              ram_en_o, ram_we_o;
  logic [AW-1:0]     ram_addr_o;
  logic [DW/8-1:0]   ram_be_o;
  logic [DW-1:0]     ram_wdata_o;
  logic [DW-1:0]     ram_rdata_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  ram_rr_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_LOCK  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .lock_i     (lock_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_be_o   (ram_be_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
  );

  // RAM model: 1-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[9:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[9:2]];
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_i = 3'b111;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (gnt_o !== 3'b000 || ram_en_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_gnt: gnt=%b en=%b, required gnt=000 en=0", gnt_o, ram_en_o);
      end
      step();
      checks++;
      if (rvalid_o !== 3'b000) begin
        errors++;
        $display("FAIL reset_rvalid: rvalid=%b, required 000", rvalid_o);
      end
    end
    rst_n = 1'b1;
    req_i = 3'b000;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (gnt_o !== 3'b000 || ram_en_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_gnt: gnt=%b en=%b, required gnt=000 en=0", gnt_o, ram_en_o);
      end
      step();
      checks++;
      if (rvalid_o !== 3'b000) begin
        errors++;
        $display("FAIL idle_rvalid: rvalid=%b, required 000", rvalid_o);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp [6];
    exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    req_i  = 3'b111;
    lock_i = 3'b000;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (gnt_o !== exp[c] || ram_en_o !== 1'b1) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: gnt=%b en=%b, required gnt=%b en=1", c, gnt_o, ram_en_o,
                 exp[c]);
      end
      step();
      checks++;
      if (rvalid_o !== exp[c]) begin
        errors++;
        $display("FAIL rr_rvalid[%0d]: rvalid=%b, required %b", c, rvalid_o, exp[c]);
      end
    end
  endtask

  // Pointer is 0 on entry; one port-0 grant moves it to 1.
  task automatic test_lock_cap();
    logic [2:0] exp [7];
    exp = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    for (int c = 0; c < 7; c++) begin
      req_i  = (c == 0) ? 3'b001 : 3'b111;
      lock_i = (c == 0) ? 3'b000 : 3'b010;
      #1;
      checks++;
      if (gnt_o !== exp[c]) begin
        errors++;
        $display("FAIL lock_cap_gnt[%0d]: gnt=%b, required %b", c, gnt_o, exp[c]);
      end
      step();
    end
  endtask

  // Pointer is 1 on entry; one port-2 grant moves it to 0.
  task automatic test_lock_idle();
    logic [2:0] rq  [6];
    logic [2:0] lk  [6];
    logic [2:0] exp [6];
    rq  = '{3'b100, 3'b001, 3'b001, 3'b000, 3'b011, 3'b011};
    lk  = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    exp = '{3'b100, 3'b001, 3'b001, 3'b000, 3'b001, 3'b010};
    for (int c = 0; c < 6; c++) begin
      req_i  = rq[c];
      lock_i = lk[c];
      #1;
      checks++;
      if (gnt_o !== exp[c]) begin
        errors++;
        $display("FAIL lock_idle_gnt[%0d]: gnt=%b, required %b", c, gnt_o, exp[c]);
      end
      step();
    end
  endtask

  // Pointer is 2 on entry.
  task automatic test_datapath();
    lock_i  = 3'b000;
    req_i   = 3'b100;
    we_i    = 3'b100;
    addr_i  = '0;
    be_i    = '0;
    wdata_i = '0;
    addr_i[0*AW +: AW]  = 32'h0000_0080;
    be_i[0 +: 4]        = 4'b1111;
    wdata_i[0*DW +: DW] = 32'h1234_5678;
    addr_i[2*AW +: AW]  = 32'h0000_0040;
    be_i[8 +: 4]        = 4'b0101;
    wdata_i[2*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (gnt_o !== 3'b100 || ram_en_o !== 1'b1 || ram_we_o !== 1'b1 ||
        ram_addr_o !== 32'h40 || ram_be_o !== 4'b0101 || ram_wdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_drive: gnt=%b en=%b we=%b addr=%h be=%b wdata=%h, required 100 1 1 00000040 0101 deadbeef",
               gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o);
    end
    step();
    checks++;
    if (rvalid_o !== 3'b100) begin
      errors++;
      $display("FAIL write_ack: rvalid=%b, required 100", rvalid_o);
    end
    req_i              = 3'b001;
    we_i               = 3'b000;
    addr_i[0*AW +: AW] = 32'h0000_0040;
    #1;
    checks++;
    if (gnt_o !== 3'b001 || ram_we_o !== 1'b0 || ram_addr_o !== 32'h40) begin
      errors++;
      $display("FAIL read_drive: gnt=%b we=%b addr=%h, required 001 0 00000040",
               gnt_o, ram_we_o, ram_addr_o);
    end
    step();
    req_i = 3'b000;
    checks++;
    if (rvalid_o !== 3'b001 || rdata_o !== 32'h00AD_00EF) begin
      errors++;
      $display("FAIL read_data: rvalid=%b rdata=%h, required 001 00ad00ef", rvalid_o, rdata_o);
    end
  endtask

  // Pointer is 1 on entry.
  task automatic test_reset_mid();
    req_i = 3'b010;
    we_i  = 3'b000;
    #1;
    checks++;
    if (gnt_o !== 3'b010) begin
      errors++;
      $display("FAIL mid_gnt: gnt=%b, required 010", gnt_o);
    end
    #1;
    rst_n = 1'b0;
    step();
    checks++;
    if (rvalid_o !== 3'b000) begin
      errors++;
      $display("FAIL mid_rvalid: rvalid=%b, required 000", rvalid_o);
    end
    rst_n = 1'b1;
    req_i = 3'b110;
    #1;
    checks++;
    if (gnt_o !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_gnt: gnt=%b, required 010", gnt_o);
    end
    step();
    req_i = 3'b000;
    checks++;
    if (rvalid_o !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_rvalid: rvalid=%b, required 010", rvalid_o);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    ram_rdata_i = '0;
    rst_n   = 1'b0;
    req_i   = '0;
    lock_i  = '0;
    we_i    = '0;
    addr_i  = '0;
    be_i    = '0;
    wdata_i = '0;
    #2;
    test_reset();
    test_round_robin();
    test_lock_cap();
    test_lock_idle();
    test_datapath();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
